// File: rtl/regfile_if.sv
// Decode/writeback-side bundle for the scoreboarded register file.
// The master drives addresses, writeback and reserve requests; the slave returns read data and hazard status.
interface regfile_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0] S_Addr;
    logic [ADDR_W-1:0] T_Addr;
    logic [DATA_W-1:0] S;
    logic [DATA_W-1:0] T;
    logic              S_BUSY;
    logic              T_BUSY;
    logic              STALL;
    logic              D_EN;
    logic [ADDR_W-1:0] D_Addr;
    logic [DATA_W-1:0] D;
    logic              RSV_EN;
    logic [ADDR_W-1:0] RSV_Addr;
    logic              RSV_RDY;
    logic [ADDR_W:0]   PEND_CNT;

    modport master (
        output S_Addr, T_Addr, D_EN, D_Addr, D, RSV_EN, RSV_Addr,
        input  S, T, S_BUSY, T_BUSY, STALL, RSV_RDY, PEND_CNT
    );

    modport slave (
        input  S_Addr, T_Addr, D_EN, D_Addr, D, RSV_EN, RSV_Addr,
        output S, T, S_BUSY, T_BUSY, STALL, RSV_RDY, PEND_CNT
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// 2-read/1-write register file with a per-register busy scoreboard for RAW hazard stalls.
// Reads, busy flags and RSV_RDY are combinational; array, busy bits and pending count are registered.
module regfile_scoreboard #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned MAX_PEND = 4
) (
    input logic       CLK,
    input logic       RESET,
    regfile_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [CNT_W-1:0]  pend_q, pend_d;

    logic s_zero, t_zero, d_zero, r_zero;
    logic s_fwd, t_fwd;
    logic wr_en, clr, acc, cap_ok, rsv_rdy;

    // Address decode shared by read, write and reserve paths
    always_comb begin
        s_zero = (ZERO_REG != 0) && (bus.S_Addr == '0);
        t_zero = (ZERO_REG != 0) && (bus.T_Addr == '0);
        d_zero = (ZERO_REG != 0) && (bus.D_Addr == '0);
        r_zero = (ZERO_REG != 0) && (bus.RSV_Addr == '0);
        s_fwd  = (BYPASS != 0) && bus.D_EN && (bus.D_Addr == bus.S_Addr);
        t_fwd  = (BYPASS != 0) && bus.D_EN && (bus.D_Addr == bus.T_Addr);
        wr_en  = bus.D_EN && !d_zero;
        clr    = wr_en && busy_q[bus.D_Addr];
    end

    // Read ports: zero register beats bypass, bypass beats the array
    always_comb begin
        bus.S = regs_q[bus.S_Addr];
        bus.T = regs_q[bus.T_Addr];
        if (s_fwd)  bus.S = bus.D;
        if (t_fwd)  bus.T = bus.D;
        if (s_zero) bus.S = '0;
        if (t_zero) bus.T = '0;
        bus.S_BUSY = busy_q[bus.S_Addr] && !s_fwd && !s_zero;
        bus.T_BUSY = busy_q[bus.T_Addr] && !t_fwd && !t_zero;
        bus.STALL  = bus.S_BUSY || bus.T_BUSY;
    end

    // A writeback that retires a reservation frees its slot in the same cycle
    always_comb begin
        cap_ok  = (pend_q - CNT_W'(clr)) < CNT_W'(MAX_PEND);
        rsv_rdy = r_zero ||
                  (cap_ok && (!busy_q[bus.RSV_Addr] ||
                              (bus.D_EN && (bus.D_Addr == bus.RSV_Addr))));
        acc     = bus.RSV_EN && rsv_rdy && !r_zero;
        bus.RSV_RDY  = rsv_rdy;
        bus.PEND_CNT = pend_q;
    end

    // Clear before set so a same-address reserve keeps the register busy
    always_comb begin
        busy_d = busy_q;
        if (clr) busy_d[bus.D_Addr]   = 1'b0;
        if (acc) busy_d[bus.RSV_Addr] = 1'b1;
        pend_d = pend_q + CNT_W'(acc) - CNT_W'(clr);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            busy_q <= '0;
            pend_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) regs_q[i] <= '0;
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
            if (wr_en) regs_q[bus.D_Addr] <= bus.D;
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against an array-based model of the register file and scoreboard.
module tb_regfile_scoreboard;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned MAXP  = 4;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    regfile_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile_scoreboard #(
        .DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1), .MAX_PEND(MAXP)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    // Reference state: plain register array and a set of busy registers
    logic [DW-1:0]    m_reg [DEPTH];
    logic [DEPTH-1:0] m_busy = '0;
    bit cmp_en = 1'b0;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_count();
        return $countones(m_busy);
    endfunction

    // Reserve acceptance from the rules: zero reg always ready; otherwise capacity after
    // any same-cycle retirement, and the target is free or being written back now.
    function automatic bit m_rdy();
        int free_now;
        if (bus.RSV_Addr == 0) return 1'b1;
        free_now = (bus.D_EN && bus.D_Addr != 0 && m_busy[bus.D_Addr]) ? 1 : 0;
        if (m_count() - free_now >= int'(MAXP)) return 1'b0;
        return !m_busy[bus.RSV_Addr] || (bus.D_EN && bus.D_Addr == bus.RSV_Addr);
    endfunction

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (bus.D_EN && bus.D_Addr == a) return bus.D;
        return m_reg[a];
    endfunction

    function automatic bit m_rbusy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        return m_busy[a] && !(bus.D_EN && bus.D_Addr == a);
    endfunction

    always @(posedge CLK) begin
        logic [DEPTH-1:0] nb;
        if (RESET === 1'b1) begin
            m_busy <= '0;
            for (int i = 0; i < int'(DEPTH); i++) m_reg[i] <= '0;
        end else if (RESET === 1'b0) begin
            nb = m_busy;
            if (bus.D_EN && bus.D_Addr != 0) begin
                m_reg[bus.D_Addr] <= bus.D;
                nb[bus.D_Addr] = 1'b0;
            end
            if (bus.RSV_EN && bus.RSV_Addr != 0 && m_rdy()) nb[bus.RSV_Addr] = 1'b1;
            m_busy <= nb;
        end
    end

    // Cycle-by-cycle comparison, away from the active edge
    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("S",        64'(bus.S),        64'(m_read(bus.S_Addr)));
            chk("T",        64'(bus.T),        64'(m_read(bus.T_Addr)));
            chk("S_BUSY",   64'(bus.S_BUSY),   64'(m_rbusy(bus.S_Addr)));
            chk("T_BUSY",   64'(bus.T_BUSY),   64'(m_rbusy(bus.T_Addr)));
            chk("STALL",    64'(bus.STALL),    64'(m_rbusy(bus.S_Addr) | m_rbusy(bus.T_Addr)));
            chk("RSV_RDY",  64'(bus.RSV_RDY),  64'(m_rdy()));
            chk("PEND_CNT", 64'(bus.PEND_CNT), 64'(m_count()));
            chk("PEND_MAX", 64'(m_count() <= int'(MAXP)), 64'd1);
        end
    end

    task automatic drive(input bit rst, input int sa, input int ta,
                         input bit den, input int da, input logic [DW-1:0] d,
                         input bit ren, input int ra);
        @(posedge CLK);
        #1;
        RESET        = rst;
        bus.S_Addr   = AW'(sa);
        bus.T_Addr   = AW'(ta);
        bus.D_EN     = den;
        bus.D_Addr   = AW'(da);
        bus.D        = d;
        bus.RSV_EN   = ren;
        bus.RSV_Addr = AW'(ra);
        #1;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, '0, 0, 0);
        drive(1, 0, 0, 0, 0, '0, 0, 0);

        // Reset state
        drive(0, 7, 7, 0, 0, '0, 0, 0);
        cmp_en = 1'b1;
        chk("rst_S", 64'(bus.S), 64'd0);
        chk("rst_T", 64'(bus.T), 64'd0);
        chk("rst_STALL", 64'(bus.STALL), 64'd0);
        chk("rst_PEND", 64'(bus.PEND_CNT), 64'd0);
        chk("rst_RDY", 64'(bus.RSV_RDY), 64'd1);

        // Zero register ignores writes and reservations
        drive(0, 1, 1, 1, 0, 32'hDEAD, 1, 0);
        chk("zero_RDY", 64'(bus.RSV_RDY), 64'd1);
        drive(0, 0, 0, 0, 0, '0, 0, 0);
        chk("zero_S", 64'(bus.S), 64'd0);
        chk("zero_PEND", 64'(bus.PEND_CNT), 64'd0);

        // Reserve r5, then retire it with bypass
        drive(0, 5, 0, 0, 0, '0, 1, 5);
        drive(0, 5, 0, 0, 0, '0, 0, 0);
        chk("r5_SBUSY", 64'(bus.S_BUSY), 64'd1);
        chk("r5_STALL", 64'(bus.STALL), 64'd1);
        chk("r5_PEND", 64'(bus.PEND_CNT), 64'd1);
        drive(0, 5, 0, 1, 5, 32'h1234, 0, 0);
        chk("byp_S", 64'(bus.S), 64'h1234);
        chk("byp_SBUSY", 64'(bus.S_BUSY), 64'd0);
        drive(0, 5, 0, 0, 0, '0, 0, 0);
        chk("byp_PEND", 64'(bus.PEND_CNT), 64'd0);
        chk("arr_S", 64'(bus.S), 64'h1234);

        // Fill the scoreboard, then free a slot with a same-cycle writeback
        for (int r = 1; r <= 4; r++) drive(0, 0, 0, 0, 0, '0, 1, r);
        drive(0, 0, 0, 0, 0, '0, 1, 6);
        chk("full_RDY", 64'(bus.RSV_RDY), 64'd0);
        chk("full_PEND", 64'(bus.PEND_CNT), 64'd4);
        drive(0, 0, 0, 1, 2, 32'h22, 1, 6);
        chk("free_RDY", 64'(bus.RSV_RDY), 64'd1);
        drive(0, 6, 2, 0, 0, '0, 0, 0);
        chk("r6_SBUSY", 64'(bus.S_BUSY), 64'd1);
        chk("r2_TBUSY", 64'(bus.T_BUSY), 64'd0);
        chk("swap_PEND", 64'(bus.PEND_CNT), 64'd4);

        // Same-address reserve and writeback: new producer keeps r3 busy
        drive(0, 0, 0, 1, 3, 32'hA5, 1, 3);
        chk("same_RDY", 64'(bus.RSV_RDY), 64'd1);
        drive(0, 3, 0, 0, 0, '0, 0, 0);
        chk("same_S", 64'(bus.S), 64'hA5);
        chk("same_SBUSY", 64'(bus.S_BUSY), 64'd1);
        chk("same_PEND", 64'(bus.PEND_CNT), 64'd4);

        // Reset overrides concurrent write and reserve
        drive(1, 0, 0, 1, 1, 32'h77, 1, 7);
        drive(0, 3, 2, 0, 0, '0, 0, 0);
        chk("rst2_S", 64'(bus.S), 64'd0);
        chk("rst2_T", 64'(bus.T), 64'd0);
        chk("rst2_STALL", 64'(bus.STALL), 64'd0);
        chk("rst2_PEND", 64'(bus.PEND_CNT), 64'd0);
        drive(0, 1, 7, 0, 0, '0, 0, 0);
        chk("rst2_r1", 64'(bus.S), 64'd0);
        chk("rst2_r7busy", 64'(bus.T_BUSY), 64'd0);

        // Randomized traffic, addresses biased to a small window to force hazards
        for (int n = 0; n < 3000; n++) begin
            int sa, ta, da, ra;
            sa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, DEPTH-1)) : int'($urandom_range(0, 7));
            ta = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, DEPTH-1)) : int'($urandom_range(0, 7));
            da = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, DEPTH-1)) : int'($urandom_range(0, 7));
            ra = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, DEPTH-1)) : int'($urandom_range(0, 7));
            drive(($urandom_range(0, 199) == 0), sa, ta,
                  ($urandom_range(0, 2) == 0), da, DW'($urandom),
                  ($urandom_range(0, 1) == 0), ra);
        end

        @(posedge CLK);
        #1;
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
